// File: rtl/panel_pkg.sv
// Shared types and constants for the PDP front-panel controller.
// Holds the state encoding, the word width and the button event decoder.
package panel_pkg;

   localparam int WORD_W       = 12;
   localparam int DEBOUNCE_DEF = 4;

   localparam int BTN_HALT  = 0;
   localparam int BTN_LOAD  = 1;
   localparam int BTN_DEP   = 2;
   localparam int BTN_EXAM  = 3;
   localparam int BTN_STEPI = 4;
   localparam int BTN_STEPM = 5;
   localparam int BTN_RUN   = 6;
   localparam int BTN_N     = 7;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ST_HALTED,
      ST_RUNNING,
      ST_STOPPING,
      ST_STEPPING,
      ST_MEM_A,
      ST_MEM_B
   } state_t;

   typedef enum logic [2:0] {
      EV_NONE,
      EV_HALT,
      EV_LOAD,
      EV_DEP,
      EV_EXAM,
      EV_STEPI,
      EV_STEPM,
      EV_RUN
   } event_t;

   // Lower-priority presses in the same cycle are dropped here.
   function automatic event_t pick_event(
      input logic [BTN_N-1:0] p
   );
      event_t e;
      e = EV_NONE;
      priority case (1'b1)
         p[BTN_HALT]:  e = EV_HALT;
         p[BTN_LOAD]:  e = EV_LOAD;
         p[BTN_DEP]:   e = EV_DEP;
         p[BTN_EXAM]:  e = EV_EXAM;
         p[BTN_STEPI]: e = EV_STEPI;
         p[BTN_STEPM]: e = EV_STEPM;
         p[BTN_RUN]:   e = EV_RUN;
         default:      e = EV_NONE;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/panel_if.sv
// Front-panel signal bundle: buttons, switch register, sequencer
// commands and the panel side of the memory bus.
interface panel_if;
   import panel_pkg::*;

   logic  sw_run;
   logic  sw_halt;
   logic  sw_stepi;
   logic  sw_stepm;
   logic  sw_loadaddr;
   logic  sw_dep;
   logic  sw_exam;
   word_t sr;
   logic  instr_end;
   word_t mem_rdata;

   logic  run;
   logic  halt;
   logic  stepi;
   logic  stepm;
   word_t mem_addr;
   word_t mem_wdata;
   logic  mem_rd;
   logic  mem_we;
   logic  panel_owns_bus;
   logic  running;
   word_t pma;
   word_t panel_data;

   modport master (
      output sw_run, sw_halt, sw_stepi, sw_stepm,
      output sw_loadaddr, sw_dep, sw_exam,
      output sr, instr_end, mem_rdata,
      input  run, halt, stepi, stepm,
      input  mem_addr, mem_wdata, mem_rd, mem_we,
      input  panel_owns_bus, running, pma, panel_data
   );

   modport slave (
      input  sw_run, sw_halt, sw_stepi, sw_stepm,
      input  sw_loadaddr, sw_dep, sw_exam,
      input  sr, instr_end, mem_rdata,
      output run, halt, stepi, stepm,
      output mem_addr, mem_wdata, mem_rd, mem_we,
      output panel_owns_bus, running, pma, panel_data
   );

endinterface

// File: rtl/panel_debounce.sv
// Per-button 2-flop synchronizer, stability counter and press detector.
// A level is accepted after DEBOUNCE equal synchronized samples.
module panel_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic i_clk,
   input  logic i_clear,
   input  logic i_raw,
   output logic o_press
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_stable;
   logic          r_stable_q;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_clear) begin
      if (i_clear) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_q <= 1'b0;
         r_press    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_s1       <= i_raw;
         r_s2       <= r_s1;
         r_stable_q <= r_stable;
         r_press    <= r_stable & ~r_stable_q;
         if (r_s2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: debounced buttons drive run/halt/step
// commands to the sequencer and examine/deposit cycles on memory.
module panel_ctrl
   import panel_pkg::*;
#(
   parameter int DEBOUNCE = DEBOUNCE_DEF
) (
   input logic     i_clk,
   input logic     i_clear,
   panel_if.slave  bus
);

   logic [BTN_N-1:0] w_raw;
   logic [BTN_N-1:0] w_press;
   event_t           w_ev;

   assign w_raw[BTN_HALT]  = bus.sw_halt;
   assign w_raw[BTN_LOAD]  = bus.sw_loadaddr;
   assign w_raw[BTN_DEP]   = bus.sw_dep;
   assign w_raw[BTN_EXAM]  = bus.sw_exam;
   assign w_raw[BTN_STEPI] = bus.sw_stepi;
   assign w_raw[BTN_STEPM] = bus.sw_stepm;
   assign w_raw[BTN_RUN]   = bus.sw_run;

   for (genvar g = 0; g < BTN_N; g++) begin : g_btn
      panel_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_db (
         .i_clk   (i_clk),
         .i_clear (i_clear),
         .i_raw   (w_raw[g]),
         .o_press (w_press[g])
      );
   end

   assign w_ev = pick_event(w_press);

   state_t r_state, w_state_nxt;
   logic   r_dep, w_dep_nxt;
   logic   r_run, w_run_nxt;
   logic   r_halt, w_halt_nxt;
   logic   r_stepi, w_stepi_nxt;
   logic   r_stepm, w_stepm_nxt;
   word_t  r_pma, w_pma_nxt;
   word_t  r_pdata, w_pdata_nxt;

   always_ff @(posedge i_clk or posedge i_clear) begin
      if (i_clear) begin
         r_state <= ST_HALTED;
         r_dep   <= 1'b0;
         r_run   <= 1'b0;
         r_halt  <= 1'b0;
         r_stepi <= 1'b0;
         r_stepm <= 1'b0;
         r_pma   <= '0;
         r_pdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dep   <= w_dep_nxt;
         r_run   <= w_run_nxt;
         r_halt  <= w_halt_nxt;
         r_stepi <= w_stepi_nxt;
         r_stepm <= w_stepm_nxt;
         r_pma   <= w_pma_nxt;
         r_pdata <= w_pdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dep_nxt   = r_dep;
      w_run_nxt   = 1'b0;
      w_halt_nxt  = 1'b0;
      w_stepi_nxt = 1'b0;
      w_stepm_nxt = 1'b0;
      w_pma_nxt   = r_pma;
      w_pdata_nxt = r_pdata;
      unique case (r_state)
         ST_HALTED: begin
            unique case (w_ev)
               EV_LOAD: w_pma_nxt = bus.sr;
               EV_DEP: begin
                  w_dep_nxt   = 1'b1;
                  w_state_nxt = ST_MEM_A;
               end
               EV_EXAM: begin
                  w_dep_nxt   = 1'b0;
                  w_state_nxt = ST_MEM_A;
               end
               EV_STEPI: begin
                  w_stepi_nxt = 1'b1;
                  w_state_nxt = ST_STEPPING;
               end
               EV_STEPM: w_stepm_nxt = 1'b1;
               EV_RUN: begin
                  w_run_nxt   = 1'b1;
                  w_state_nxt = ST_RUNNING;
               end
               default: ;
            endcase
         end
         ST_RUNNING: begin
            if (w_ev == EV_HALT) begin
               w_halt_nxt  = 1'b1;
               w_state_nxt = ST_STOPPING;
            end
         end
         ST_STOPPING, ST_STEPPING: begin
            if (bus.instr_end) w_state_nxt = ST_HALTED;
         end
         ST_MEM_A: begin
            if (!r_dep) w_pdata_nxt = bus.mem_rdata;
            w_state_nxt = ST_MEM_B;
         end
         ST_MEM_B: begin
            w_pma_nxt   = r_pma + 1'b1;
            w_state_nxt = ST_HALTED;
         end
         default: w_state_nxt = ST_HALTED;
      endcase
   end

   assign bus.run   = r_run;
   assign bus.halt  = r_halt;
   assign bus.stepi = r_stepi;
   assign bus.stepm = r_stepm;

   assign bus.mem_addr  = r_pma;
   assign bus.mem_wdata = bus.sr;
   assign bus.mem_rd    = (r_state == ST_MEM_A) & ~r_dep;
   assign bus.mem_we    = (r_state == ST_MEM_A) & r_dep;

   assign bus.panel_owns_bus = (r_state == ST_HALTED)
                             | (r_state == ST_MEM_A)
                             | (r_state == ST_MEM_B);
   assign bus.running = (r_state == ST_RUNNING)
                      | (r_state == ST_STOPPING);

   assign bus.pma        = r_pma;
   assign bus.panel_data = r_pdata;

endmodule

// File: doc/panel_ctrl.md
PANEL_CTRL -- requirements
Module: panel_ctrl

Interface
REQ-001 Parameter: DEBOUNCE, default 4, consecutive stable synchronized cycles required before a button level is accepted.
REQ-002 CLK  in  1  PDP clock; the only clock.
REQ-003 CLEAR  in  1  reset; asynchronous, active-high.
REQ-004 SW_RUN, SW_HALT, SW_STEPI, SW_STEPM, SW_LOADADDR, SW_DEP, SW_EXAM  in  1 each  raw front-panel pushbuttons, asynchronous, active-high.
REQ-005 SR  in  12  switch register.
REQ-006 INSTR_END  in  1  one-cycle pulse from the sequencer at the final step of an instruction.
REQ-007 MEM_RDATA  in  12  memory read data, valid in the cycle MEM_RD is high.
REQ-008 RUN, HALT, STEPI, STEPM  out  1 each  one-cycle command pulses to the sequencer.
REQ-009 MEM_ADDR  out  12  panel memory address, equal to PMA.
REQ-010 MEM_WDATA  out  12  panel write data, equal to SR.
REQ-011 MEM_RD, MEM_WE  out  1 each  panel memory read and write strobes.
REQ-012 PANEL_OWNS_BUS  out  1  high when the panel may drive the memory bus.
REQ-013 RUNNING  out  1  CPU run lamp.
REQ-014 PMA, PANEL_DATA  out  12 each  panel address register; last examined word.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer and a debouncer; a debounced rising edge SHALL generate a one-cycle press event.
REQ-016 For a raw button first sampled high at edge N and held, the press event SHALL be high in cycle N+DEBOUNCE+2; a bounce shorter than DEBOUNCE cycles SHALL produce no event.
REQ-017 FSM states: HALTED, RUNNING, STOPPING, STEPPING, MEM_A, MEM_B.
REQ-018 Simultaneous events priority: HALT > LOADADDR > DEP > EXAM > STEPI > STEPM > RUN; lower-priority events in the same cycle SHALL be discarded.
REQ-019 HALTED + RUN: pulse RUN, go to RUNNING.
REQ-020 HALTED + STEPI: pulse STEPI, go to STEPPING.
REQ-021 HALTED + STEPM: pulse STEPM, stay in HALTED.
REQ-022 RUNNING + HALT: pulse HALT, go to STOPPING.
REQ-023 STOPPING + INSTR_END: go to HALTED; STEPPING + INSTR_END: go to HALTED.
REQ-024 Command pulses SHALL be registered and assert in the cycle after the event.
REQ-025 Events that are not listed for the current state SHALL be ignored; this includes every event in STOPPING, STEPPING, MEM_A and MEM_B, and HALT while in HALTED.
REQ-026 HALTED + LOADADDR: PMA <= SR; no memory cycle.
REQ-027 HALTED + DEP or EXAM: go to MEM_A, then MEM_B, then HALTED.
REQ-028 In MEM_A, MEM_RD or MEM_WE SHALL be high for one cycle, with MEM_ADDR=PMA.
REQ-029 EXAM: PANEL_DATA SHALL capture MEM_RDATA at the end of MEM_A.
REQ-030 In MEM_B, PMA SHALL increment modulo 4096 (7777 octal wraps to 0000).
REQ-031 PANEL_OWNS_BUS SHALL be 1 in HALTED, MEM_A and MEM_B, and 0 otherwise.
REQ-032 RUNNING output SHALL be 1 in RUNNING and STOPPING.
REQ-033 MEM_RD and MEM_WE SHALL never be high together and never high while PANEL_OWNS_BUS=0.

Reset
REQ-034 CLEAR SHALL force HALTED and set all outputs, PMA, PANEL_DATA, synchronizers and debounce state to 0, including in the middle of a memory cycle.
REQ-035 A button held through CLEAR SHALL produce one press event DEBOUNCE+2 cycles after CLEAR deasserts.

Structure
REQ-036 Package panel_pkg SHALL hold the state encoding, the word-width constant (12) and the DEBOUNCE default.
REQ-037 Sub-module panel_debounce (synchronizer, counter, edge detector) SHALL be instantiated once per button.

Verification
REQ-038 DEBOUNCE=4, SW_RUN held from edge 10: RUN pulse at cycle 17 only, RUNNING=1, PANEL_OWNS_BUS=0.
REQ-039 Running, HALT pressed, INSTR_END 5 cycles after the HALT pulse: RUNNING stays 1 until INSTR_END, HALTED in the next cycle.
REQ-040 SR=7776, LOADADDR, then DEP twice with SR=0123 and then SR=4567: writes go to 7776 and 7777, and PMA ends at 0000.
REQ-041 PMA=0200, EXAM with MEM_RDATA=5252: MEM_RD high for 1 cycle, PANEL_DATA=5252, PMA=0201.
REQ-042 HALT and DEP events in the same cycle while HALTED: no pulse, no write; DEP while RUNNING: no MEM_WE.
REQ-043 CLEAR asserted in MEM_A of a deposit: MEM_WE drops immediately, state is HALTED, PMA=0.
